// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the program ROM address from a PC register and
// registers the returned instruction for the decoder, with stall, branch and halt control.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'd0)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic               iHalt,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPC,
  output logic               oValid,
  output logic [15:0]        oFetchCount
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    opc_q, opc_d;
  logic                 valid_q, valid_d;
  logic [15:0]          count_q, count_d;

  logic in_run;
  logic halt_req;
  logic redirect;
  logic capture;
  logic count_sat;

  // Priority in RUN: halt over branch over stall.
  assign in_run    = (state_q == StRun);
  assign halt_req  = in_run && iHalt;
  assign redirect  = in_run && !iHalt && iBranchTaken;
  assign capture   = in_run && !iHalt && !iBranchTaken && !iStall;
  assign count_sat = &count_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    count_d = count_q;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        valid_d = 1'b0;
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
          valid_d = 1'b0;
        end else if (redirect) begin
          pc_d    = iBranchTarget;
          valid_d = 1'b0;
        end else if (capture) begin
          instr_d = iInstruction;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          if (!count_sat) begin
            count_d = count_q + 16'd1;
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StBoot;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = instr_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;
  assign oFetchCount  = count_q;

endmodule
